// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: default operand geometry, loader FSM states and the
// operand register array type consumed by the GEMM stage.
package gemm_pkg;

   localparam int DEF_DATA_WIDTH    = 64;
   localparam int DEF_MATRIX_HEIGHT = 4;
   localparam int DEF_MATRIX_WIDTH  = 4;

   // Stream is alpha, beta, then A, B and C each row-major.
   localparam int DEF_STREAM_LEN = 2 + 3 * DEF_MATRIX_HEIGHT * DEF_MATRIX_WIDTH;

   typedef enum logic [1:0] {
      LOAD      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } ldr_state_e;

   typedef logic signed [DEF_DATA_WIDTH-1:0] gemm_mat_t [DEF_MATRIX_HEIGHT][DEF_MATRIX_WIDTH];

   function automatic int stream_len(input int h, input int w);
      return 2 + 3 * h * w;
   endfunction

endpackage

// File: rtl/gemm_operand_loader.sv
// Assembles alpha, beta, A, B, C from a valid/ready word stream; ostart one cycle after the last word.
// oready is low from the final word until GEMM done (or isoft_clr); held operands stay stable meanwhile.
module gemm_operand_loader
   import gemm_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int MATRIX_HEIGHT = DEF_MATRIX_HEIGHT,
   parameter int MATRIX_WIDTH  = DEF_MATRIX_WIDTH
) (
   input  logic                         iclk,
   input  logic                         irst_n,
   input  logic                         isoft_clr,
   input  logic                         ivalid,
   input  logic signed [DATA_WIDTH-1:0] idata,
   output logic                         oready,
   output logic        [DATA_WIDTH-1:0] oalpha,
   output logic        [DATA_WIDTH-1:0] obeta,
   output logic signed [DATA_WIDTH-1:0] oa_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
   output logic signed [DATA_WIDTH-1:0] ob_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
   output logic signed [DATA_WIDTH-1:0] oc_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
   output logic                         ostart,
   input  logic                         igemm_busy,
   input  logic                         igemm_done,
   output logic                         oloaded
);

   localparam int N   = MATRIX_HEIGHT * MATRIX_WIDTH;
   localparam int LEN = stream_len(MATRIX_HEIGHT, MATRIX_WIDTH);
   localparam int CW  = $clog2(LEN);
   localparam int RW  = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
   localparam int KW  = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
   localparam logic [CW-1:0] A_BASE   = CW'(2);
   localparam logic [CW-1:0] B_BASE   = CW'(2 + N);
   localparam logic [CW-1:0] C_BASE   = CW'(2 + 2 * N);
   localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_HEIGHT - 1);
   localparam logic [KW-1:0] COL_LAST = KW'(MATRIX_WIDTH - 1);

   ldr_state_e r_state;
   ldr_state_e w_next;

   logic [CW-1:0]                r_cnt;
   logic [RW-1:0]                r_row;
   logic [KW-1:0]                r_col;
   logic                         r_ready;
   logic                         r_start;
   logic                         r_loaded;
   logic        [DATA_WIDTH-1:0] r_alpha;
   logic        [DATA_WIDTH-1:0] r_beta;
   logic signed [DATA_WIDTH-1:0] r_a [MATRIX_HEIGHT][MATRIX_WIDTH];
   logic signed [DATA_WIDTH-1:0] r_b [MATRIX_HEIGHT][MATRIX_WIDTH];
   logic signed [DATA_WIDTH-1:0] r_c [MATRIX_HEIGHT][MATRIX_WIDTH];

   logic w_accept;
   logic w_last;

   // An abort in the same cycle wins over the handshake and drops the word.
   assign w_accept = ivalid & r_ready & ~isoft_clr;
   assign w_last   = w_accept && (r_cnt == CNT_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         LOAD:      if (w_last) w_next = ISSUE;
         ISSUE:     w_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (igemm_done)      w_next = LOAD;
            else if (igemm_busy) w_next = WAIT_DONE;
         end
         WAIT_DONE: if (igemm_done) w_next = LOAD;
         default:   w_next = LOAD;
      endcase
      if (isoft_clr) w_next = LOAD;
   end

   // Status outputs are registered from the next state so they stay low through reset.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_state  <= LOAD;
         r_ready  <= 1'b0;
         r_start  <= 1'b0;
         r_loaded <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_ready  <= (w_next == LOAD);
         r_start  <= (w_next == ISSUE);
         r_loaded <= (w_next != LOAD);
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_cnt <= '0;
         r_row <= '0;
         r_col <= '0;
      end else if (isoft_clr) begin
         r_cnt <= '0;
         r_row <= '0;
         r_col <= '0;
      end else if (w_accept) begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         if (r_cnt >= A_BASE) begin
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_alpha <= '0;
         r_beta  <= '0;
         for (int i = 0; i < MATRIX_HEIGHT; i++) begin
            for (int j = 0; j < MATRIX_WIDTH; j++) begin
               r_a[i][j] <= '0;
               r_b[i][j] <= '0;
               r_c[i][j] <= '0;
            end
         end
      end else if (w_accept) begin
         if (r_cnt == '0)         r_alpha           <= idata;
         else if (r_cnt < A_BASE) r_beta            <= idata;
         else if (r_cnt < B_BASE) r_a[r_row][r_col] <= idata;
         else if (r_cnt < C_BASE) r_b[r_row][r_col] <= idata;
         else                     r_c[r_row][r_col] <= idata;
      end
   end

   assign oready    = r_ready;
   assign ostart    = r_start;
   assign oloaded   = r_loaded;
   assign oalpha    = r_alpha;
   assign obeta     = r_beta;
   assign oa_matrix = r_a;
   assign ob_matrix = r_b;
   assign oc_matrix = r_c;

endmodule
